// File: rtl/ball_ctrl.sv
// ball_ctrl: ball motion controller for the ping-pong game.
// Holds the ball position and direction and advances the ball once per frame.
// The ball bounces off the top and bottom screen borders, the wall and the bar.
// A miss parks the ball for MISS_FRAMES frames and then re-centres it.
//
// Ports:
//   clk, rst                  pixel clock; asynchronous active-high reset
//   frame_tick                one-cycle pulse per frame (vertical blanking)
//   start                     serve request, sampled every cycle, used in IDLE only
//   wall_x_r                  right edge of the wall
//   bar_x_l/bar_y_t/bar_y_b   left, top and bottom edges of the bar
//   ball_x_l/x_r/y_t/y_b      registered ball bounding box
//   playing                   high while in PLAY
//   hit, miss                 one-cycle pulses, aligned with the position update
//
// Optional feature:
//   BALL_SPEEDUP_EN defined -> each bar hit raises the speed by 1, up to
//   BALL_V_MAX. The speed is reloaded with BALL_V on serve and on reset.
module ball_ctrl #(
  parameter int MAX_X       = 640,
  parameter int MAX_Y       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_V      = 2,
  parameter int BALL_V_MAX  = 6,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] wall_x_r,
  input  logic [9:0] bar_x_l,
  input  logic [9:0] bar_y_t,
  input  logic [9:0] bar_y_b,
  output logic [9:0] ball_x_l,
  output logic [9:0] ball_x_r,
  output logic [9:0] ball_y_t,
  output logic [9:0] ball_y_b,
  output logic       playing,
  output logic       hit,
  output logic       miss
);

`ifdef BALL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [10:0] BS    = 11'(BALL_SIZE);
  localparam logic [10:0] CX    = 11'(MAX_X / 2 - BALL_SIZE / 2);
  localparam logic [10:0] CY    = 11'(MAX_Y / 2 - BALL_SIZE / 2);
  localparam logic [10:0] X_LIM = 11'(MAX_X - 2);
  localparam logic [10:0] Y_LIM = 11'(MAX_Y - 2);
  localparam logic [10:0] Y_BOT = 11'(MAX_Y - 1 - BALL_SIZE);
  localparam logic [10:0] V0    = 11'(BALL_V);
  // Without speed-up the cap equals the serve speed, so v never changes.
  localparam logic [10:0] V_CAP = SPEEDUP ? 11'(BALL_V_MAX) : V0;
  localparam int          CW    = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, MISS} state_t;

  state_t        state_q, state_d;
  logic [10:0]   x_l_q, x_l_d, y_t_q, y_t_d, x_r_q, y_b_q;
  logic [10:0]   v_q, v_d;
  logic          dir_x_q, dir_x_d;   // 1 = right
  logic          dir_y_q, dir_y_d;   // 1 = down
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_d, miss_d, hit_q, miss_q;

  logic [10:0]   wall_r, bar_l, bar_t, bar_b;
  logic [10:0]   y_step;
  logic          dir_y_step;
  logic          bar_hit;

  assign wall_r = {1'b0, wall_x_r};
  assign bar_l  = {1'b0, bar_x_l};
  assign bar_t  = {1'b0, bar_y_t};
  assign bar_b  = {1'b0, bar_y_b};

  always_comb begin
    y_step     = y_t_q;
    dir_y_step = dir_y_q;
    if (dir_y_q) begin
      if (y_b_q + v_q > Y_LIM) begin
        y_step     = Y_BOT;
        dir_y_step = 1'b0;
      end else begin
        y_step = y_t_q + v_q;
      end
    end else begin
      if (y_t_q < v_q + 11'd1) begin
        y_step     = 11'd1;
        dir_y_step = 1'b1;
      end else begin
        y_step = y_t_q - v_q;
      end
    end
    bar_hit = dir_x_q && (x_r_q + v_q >= bar_l) && (x_r_q < bar_l) &&
              (y_b_q >= bar_t) && (y_t_q <= bar_b);
  end

  always_comb begin
    state_d = state_q;
    x_l_d   = x_l_q;
    y_t_d   = y_t_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      IDLE: begin
        x_l_d = CX;
        y_t_d = CY;
        if (start) begin
          state_d = PLAY;
          dir_x_d = 1'b1;
          dir_y_d = 1'b1;
          v_d     = V0;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          y_t_d   = y_step;
          dir_y_d = dir_y_step;
          if (!dir_x_q) begin
            if (x_l_q < wall_r + 11'd1 + v_q) begin
              x_l_d   = wall_r + 11'd1;
              dir_x_d = 1'b1;
            end else begin
              x_l_d = x_l_q - v_q;
            end
          end else if (bar_hit) begin
            x_l_d   = bar_l - BS;
            dir_x_d = 1'b0;
            hit_d   = 1'b1;
            if (v_q < V_CAP) v_d = v_q + 11'd1;
          end else if (x_r_q + v_q > X_LIM) begin
            // A miss freezes the whole position, so undo the y step taken above.
            state_d = MISS;
            miss_d  = 1'b1;
            cnt_d   = '0;
            y_t_d   = y_t_q;
            dir_y_d = dir_y_q;
          end else begin
            x_l_d = x_l_q + v_q;
          end
        end
      end
      MISS: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            x_l_d   = CX;
            y_t_d   = CY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_l_q   <= CX;
      x_r_q   <= CX + BS - 11'd1;
      y_t_q   <= CY;
      y_b_q   <= CY + BS - 11'd1;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      v_q     <= V0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_l_q   <= x_l_d;
      x_r_q   <= x_l_d + BS - 11'd1;
      y_t_q   <= y_t_d;
      y_b_q   <= y_t_d + BS - 11'd1;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign ball_x_l = x_l_q[9:0];
  assign ball_x_r = x_r_q[9:0];
  assign ball_y_t = y_t_q[9:0];
  assign ball_y_b = y_b_q[9:0];
  assign playing  = (state_q == PLAY);
  assign hit      = hit_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Testbench for ball_ctrl: directed serve/bounce/hit/miss scenarios followed by
// randomized bar/wall geometry, serve requests and frame ticks, all compared
// against a frame-level reference model of the ball rules.
module tb_ball_ctrl;

  localparam int MAX_X = 640;
  localparam int MAX_Y = 480;
  localparam int BS    = 8;
  localparam int V0    = 2;
`ifdef BALL_SPEEDUP_EN
  localparam int VMAX  = 6;
`else
  localparam int VMAX  = V0;
`endif
  localparam int MISS_FRAMES = 60;
  localparam int CX = MAX_X / 2 - BS / 2;
  localparam int CY = MAX_Y / 2 - BS / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic [9:0] wall_x_r, bar_x_l, bar_y_t, bar_y_b;
  logic [9:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
  logic       playing, hit, miss;

  int checks   = 0;
  int failures = 0;

  // Reference model state: mode 0 = parked, 1 = in play, 2 = after a miss.
  int m_mode, m_x, m_y, m_dx, m_dy, m_v, m_cnt;
  int m_hit, m_miss;

  always #5 clk = ~clk;

  ball_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .wall_x_r   (wall_x_r),
    .bar_x_l    (bar_x_l),
    .bar_y_t    (bar_y_t),
    .bar_y_b    (bar_y_b),
    .ball_x_l   (ball_x_l),
    .ball_x_r   (ball_x_r),
    .ball_y_t   (ball_y_t),
    .ball_y_b   (ball_y_b),
    .playing    (playing),
    .hit        (hit),
    .miss       (miss)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    check("ball_x_l", 32'(ball_x_l), 32'(m_x));
    check("ball_x_r", 32'(ball_x_r), 32'(m_x + BS - 1));
    check("ball_y_t", 32'(ball_y_t), 32'(m_y));
    check("ball_y_b", 32'(ball_y_b), 32'(m_y + BS - 1));
    check("playing",  32'(playing),  32'(m_mode == 1));
    check("hit",      32'(hit),      32'(m_hit));
    check("miss",     32'(miss),     32'(m_miss));
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
    m_v = V0; m_cnt = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_step(input bit st, input bit ft);
    int ny, ndy, wall, bl, bt, bb;
    wall = int'(wall_x_r); bl = int'(bar_x_l); bt = int'(bar_y_t); bb = int'(bar_y_b);
    m_hit = 0;
    m_miss = 0;
    if (m_mode == 0) begin
      m_x = CX; m_y = CY;
      if (st) begin m_mode = 1; m_dx = 1; m_dy = 1; m_v = V0; end
    end else if (m_mode == 1) begin
      if (ft) begin
        ny = m_y; ndy = m_dy;
        if (m_dy > 0) begin
          if (m_y + BS - 1 + m_v > MAX_Y - 2) begin ny = MAX_Y - 1 - BS; ndy = -1; end
          else ny = m_y + m_v;
        end else begin
          if (m_y < m_v + 1) begin ny = 1; ndy = 1; end
          else ny = m_y - m_v;
        end
        if (m_dx < 0) begin
          if (m_x < wall + 1 + m_v) begin m_x = wall + 1; m_dx = 1; end
          else m_x = m_x - m_v;
        end else if ((m_x + BS - 1 + m_v >= bl) && (m_x + BS - 1 < bl) &&
                     (m_y + BS - 1 >= bt) && (m_y <= bb)) begin
          m_x = bl - BS; m_dx = -1; m_hit = 1;
          m_v = (m_v + 1 > VMAX) ? VMAX : m_v + 1;
        end else if (m_x + BS - 1 + m_v > MAX_X - 2) begin
          m_mode = 2; m_miss = 1; m_cnt = 0;
        end else begin
          m_x = m_x + m_v;
        end
        if (!m_miss) begin m_y = ny; m_dy = ndy; end
      end
    end else begin
      if (ft) begin
        m_cnt++;
        if (m_cnt == MISS_FRAMES) begin m_mode = 0; m_cnt = 0; m_x = CX; m_y = CY; end
      end
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 after checking everything.
  task automatic cycle(input bit st, input bit ft);
    start = st;
    frame_tick = ft;
    model_step(st, ft);
    @(posedge clk);
    #1;
    start = 1'b0;
    frame_tick = 1'b0;
    check_all();
  endtask

  // Asserts reset between clock edges and checks the outputs react immediately.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    int min_x;
    rst = 1'b0; start = 1'b0; frame_tick = 1'b0;
    wall_x_r = 10'd35; bar_x_l = 10'd600; bar_y_t = 10'd0; bar_y_b = 10'd479;
    #2;
    do_reset();
    check("reset_x_l", 32'(ball_x_l), 32'd316);
    check("reset_y_b", 32'(ball_y_b), 32'd243);

    // Idle tick does nothing; serve.
    cycle(1'b0, 1'b1);
    check("idle_tick_x", 32'(ball_x_l), 32'd316);
    cycle(1'b1, 1'b0);
    check("serve_playing", 32'(playing), 32'd1);

    // Bar spans the whole height: bottom bounce, bar hit, wall bounce.
    min_x = 1000;
    for (int n = 1; n <= 420; n++) begin
      cycle(1'b0, 1'b1);
      if (int'(ball_x_l) < min_x) min_x = int'(ball_x_l);
      if (n == 1) begin
        check("first_x_l", 32'(ball_x_l), 32'd318);
        check("first_y_b", 32'(ball_y_b), 32'd245);
      end
      if (n == 118) check("bottom_clamp_y", 32'(ball_y_t), 32'd471);
      if (n == 119) check("bottom_bounce_y", 32'(ball_y_t), 32'd469);
      if (n == 139) begin
        check("bar_hit_pulse", 32'(hit), 32'd1);
        check("bar_hit_x", 32'(ball_x_l), 32'd592);
      end
`ifdef BALL_SPEEDUP_EN
      if (n == 140) check("after_hit_x", 32'(ball_x_l), 32'd589);
`else
      if (n == 140) check("after_hit_x", 32'(ball_x_l), 32'd590);
      if (n == 418) check("wall_clamp_x", 32'(ball_x_l), 32'd36);
      if (n == 419) check("wall_rise_x", 32'(ball_x_l), 32'd38);
`endif
      cycle(1'b0, 1'b0);
    end
`ifndef BALL_SPEEDUP_EN
    check("wall_min_x", 32'(min_x), 32'd36);
`endif

    // Async reset mid-PLAY.
    #3;
    do_reset();
    check("midplay_reset_hit", 32'(hit), 32'd0);

    // Miss and recovery; start+tick together serves without moving.
    bar_y_t = 10'd0; bar_y_b = 10'd10;
    cycle(1'b1, 1'b1);
    check("serve_tick_x", 32'(ball_x_l), 32'd316);
    for (int n = 1; n <= 158; n++) begin
      cycle(1'b0, 1'b1);
      if (n == 158) begin
        check("miss_pulse", 32'(miss), 32'd1);
        check("miss_playing", 32'(playing), 32'd0);
        check("miss_frozen_x", 32'(ball_x_l), 32'd630);
      end
      cycle(1'b0, 1'b0);
    end
    // start is asserted now and then during MISS and must be ignored.
    for (int k = 1; k <= MISS_FRAMES; k++) begin
      cycle((k % 7) == 0, 1'b1);
      if (k == MISS_FRAMES - 1) check("miss_hold_x", 32'(ball_x_l), 32'd630);
      cycle(1'b0, 1'b0);
    end
    check("recentre_x", 32'(ball_x_l), 32'd316);
    check("recentre_y", 32'(ball_y_t), 32'd236);
    check("recentre_idle", 32'(playing), 32'd0);
    cycle(1'b1, 1'b0);
    check("reserve_playing", 32'(playing), 32'd1);

    // Randomized geometry, ticks, serves and occasional async resets.
    for (int r = 0; r < 5; r++) begin
      wall_x_r = 10'($urandom_range(0, 150));
      bar_x_l  = 10'($urandom_range(330, 630));
      bar_y_t  = 10'($urandom_range(0, 470));
      bar_y_b  = 10'($urandom_range(int'(bar_y_t), 479));
      #3;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 999) == 0) begin
          #3;
          do_reset();
        end else begin
          cycle($urandom_range(0, 20) == 0, $urandom_range(0, 3) == 0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
# ball_ctrl

Ball motion controller for the ping-pong game: holds the ball's position and direction, advances it once per frame, bounces it off the screen border, the wall and the bar, and detects a miss. It sits directly upstream of the pixel-level object renderer and drives its ball bounding-box inputs (`ball_x_l`, `ball_x_r`, `ball_y_t`, `ball_y_b`). It also consumes the same wall and bar coordinates the renderer draws.

## Interface
Parameters:
- `MAX_X`, 640, screen width in pixels
- `MAX_Y`, 480, screen height in pixels
- `BALL_SIZE`, 8, ball edge length in pixels
- `BALL_V`, 2, pixels moved per frame on each axis
- `BALL_V_MAX`, 6, speed ceiling; used only with `BALL_SPEEDUP_EN`
- `MISS_FRAMES`, 60, frames held in MISS before re-centring

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset; asynchronous, active-high (already decided)
- `frame_tick`  in  1  one-cycle pulse per frame, asserted during vertical blanking
- `start`  in  1  serve request; level or pulse, sampled every cycle
- `wall_x_r`  in  10  right edge of wall
- `bar_x_l`, `bar_y_t`, `bar_y_b`  in  10 each  bar left, top and bottom edges
- `ball_x_l`, `ball_x_r`, `ball_y_t`, `ball_y_b`  out  10 each  registered ball bounding box
- `playing`  out  1  high in PLAY
- `hit`  out  1  one-cycle pulse on a bar hit
- `miss`  out  1  one-cycle pulse on a miss

## Operation
FSM states: IDLE, PLAY, MISS.

IDLE:
- Ball parked at centre: `x_l = MAX_X/2 - BALL_SIZE/2` (316), `y_t = MAX_Y/2 - BALL_SIZE/2` (236).
- `start` high → PLAY, with dir_x = right, dir_y = down, and speed v = `BALL_V`.

PLAY, on each `frame_tick`: rules are evaluated on the current position, in the following priority order per axis. V denotes the current speed.
- Y axis, moving up: if `y_t < V+1`, then `y_t ← 1` and dir_y ← down; else `y_t ← y_t - V`.
- Y axis, moving down: if `y_t + BALL_SIZE - 1 + V > MAX_Y - 2`, then `y_t ← MAX_Y - 1 - BALL_SIZE` and dir_y ← up; else `y_t ← y_t + V`.
- X axis, moving left: if `x_l < wall_x_r + 1 + V`, then `x_l ← wall_x_r + 1` and dir_x ← right; else `x_l ← x_l - V`.
- X axis, moving right, bar hit: applies when `x_r + V >= bar_x_l`, `x_r < bar_x_l`, `y_b >= bar_y_t` and `y_t <= bar_y_b`. Then `x_l ← bar_x_l - BALL_SIZE`, dir_x ← left, and `hit` pulses.
- X axis, moving right, miss: applies when no bar hit and `x_r + V > MAX_X - 2`. Then → MISS, `miss` pulses, and the position is frozen (the y update for that tick is also suppressed).
- X axis, moving right, otherwise: `x_l ← x_l + V`.

MISS:
- Counts `frame_tick`s.
- After `MISS_FRAMES` ticks → IDLE, with the position re-centred on the same cycle.

Other rules:
- `start` is ignored outside IDLE.
- All arithmetic uses 11-bit unsigned internals, so sums cannot wrap. Outputs are the low 10 bits; in-range values are guaranteed by the clamps.
- `ball_x_r = x_l + BALL_SIZE - 1` and `ball_y_b = y_t + BALL_SIZE - 1` are registered in the same cycle as `x_l` and `y_t`.

## Timing
- Reset (asynchronous) forces IDLE. Reset values: `ball_x_l`=316, `ball_x_r`=323, `ball_y_t`=236, `ball_y_b`=243, `playing`=0, `hit`=0, `miss`=0. The speed register returns to `BALL_V` and the miss counter to 0. Reset mid-PLAY or mid-MISS behaves identically.
- Position outputs update in the cycle after a `frame_tick`, then hold until the next tick. They are therefore stable throughout active video.
- `hit` and `miss` are high for exactly the cycle in which the position updates.
- `playing` goes high one cycle after `start` is sampled in IDLE.
- `start` and `frame_tick` in the same IDLE cycle: enter PLAY with no movement on that tick.
- `frame_tick` while in IDLE: no effect.

## Configuration
- `BALL_SPEEDUP_EN` defined: each bar hit sets v ← min(v+1, `BALL_V_MAX`), with the new speed taking effect from the next tick. v is reloaded to `BALL_V` on serve and on reset.
- `BALL_SPEEDUP_EN` undefined: v is constant at `BALL_V`, and `BALL_V_MAX` is unused.

## Test plan
Unless stated otherwise, scenarios use `wall_x_r`=35 and `bar_x_l`=600.
- Serve and first move: reset, then `start`, then one `frame_tick` → `ball_x_l`=318, `ball_x_r`=325, `ball_y_t`=238, `ball_y_b`=245, `playing`=1.
- Bottom bounce: continue ticking → after tick 118, `ball_y_t`=471 and `ball_y_b`=478. The next tick gives `ball_y_t`=469.
- Bar hit: `bar_y_t`=0, `bar_y_b`=479 → on tick 139, `ball_x_l`=592 with a one-cycle `hit`. The following tick gives `ball_x_l`=590 (or 589 with `BALL_SPEEDUP_EN`).
- Wall bounce: continue the bar-hit run with the macro undefined → `ball_x_l` never goes below 36, and after clamping at 36 it rises to 38.
- Miss and recovery: `bar_y_t`=0, `bar_y_b`=10 → on tick 158, `miss` pulses, `playing`=0 and the position freezes. After 60 more ticks, the position is 316/236 and a new `start` is accepted.
- Async reset mid-PLAY: assert `rst` between clock edges → outputs immediately return to their reset values; `hit`/`miss` never glitch high.
